// File: rtl/rvh2rrv_ruby_resp_packer.sv
// Packs L1D load/store responses into ruby responses, tracking outstanding ruby tags.
// Optional feature macro RVH_RUBY_RESP_CHECK_EN adds sticky resp_err_o and drops bad responses.
module rvh2rrv_ruby_resp_packer #(
  parameter int TAG_W  = 3,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ruby_req_valid_i,
  output logic              ruby_req_ready_o,
  input  logic [5:0]        ruby_req_type_i,
  input  logic [TAG_W-1:0]  ruby_req_tag_i,
  input  logic              ld_resp_valid_i,
  output logic              ld_resp_ready_o,
  input  logic [TAG_W-1:0]  ld_resp_tag_i,
  input  logic [DATA_W-1:0] ld_resp_data_i,
  input  logic              st_resp_valid_i,
  output logic              st_resp_ready_o,
  input  logic [TAG_W-1:0]  st_resp_tag_i,
  output logic              ruby_resp_valid_o,
  input  logic              ruby_resp_ready_i,
  output logic [5:0]        ruby_resp_type_o,
  output logic [TAG_W-1:0]  ruby_resp_tag_o,
  output logic [DATA_W-1:0] ruby_resp_data_o,
  output logic [TAG_W:0]    inflight_cnt_o
`ifdef RVH_RUBY_RESP_CHECK_EN
  ,
  output logic              resp_err_o
`endif
);

  localparam int DEPTH = 1 << TAG_W;

  function automatic logic type_is_ld(input logic [5:0] req_type);
    case (req_type)
      6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd34, 6'd36: type_is_ld = 1'b1;
      default:                                                type_is_ld = 1'b0;
    endcase
  endfunction

  logic [DEPTH-1:0]  valid_r;
  logic [5:0]        type_r [DEPTH];
  logic              resp_valid_r;
  logic [5:0]        resp_type_r;
  logic [TAG_W-1:0]  resp_tag_r;
  logic [DATA_W-1:0] resp_data_r;
  logic [TAG_W:0]    inflight_r;

  logic              out_free_s;
  logic              req_fire_s;
  logic              ld_fire_s;
  logic              st_fire_s;
  logic              rsp_fire_s;
  logic              fwd_s;
  logic              free_s;
  logic [TAG_W-1:0]  rsp_tag_s;
  logic [DATA_W-1:0] rsp_data_s;
  logic [TAG_W:0]    inflight_nxt_s;

`ifdef RVH_RUBY_RESP_CHECK_EN
  logic [DEPTH-1:0]  is_ld_r;
  logic              bad_s;
  logic              resp_err_r;
`endif

  // Handshake decode: load wins the output slot, request stalls on a busy tag.
  always_comb begin
    out_free_s = !resp_valid_r || ruby_resp_ready_i;
    req_fire_s = ruby_req_valid_i && !valid_r[ruby_req_tag_i];
    ld_fire_s  = ld_resp_valid_i && out_free_s;
    st_fire_s  = st_resp_valid_i && out_free_s && !ld_resp_valid_i;
    rsp_fire_s = ld_fire_s || st_fire_s;
    if (ld_fire_s) begin
      rsp_tag_s  = ld_resp_tag_i;
      rsp_data_s = ld_resp_data_i;
    end else begin
      rsp_tag_s  = st_resp_tag_i;
      rsp_data_s = {DATA_W{1'b0}};
    end
`ifdef RVH_RUBY_RESP_CHECK_EN
    bad_s = !valid_r[rsp_tag_s] || (is_ld_r[rsp_tag_s] != ld_fire_s);
    fwd_s = rsp_fire_s && !bad_s;
`else
    fwd_s = rsp_fire_s;
`endif
    // Only a live entry contributes to the popcount, so only it may decrement.
    free_s = fwd_s && valid_r[rsp_tag_s];
  end

  // Outstanding count: a request and a free never target the same live tag.
  always_comb begin
    case ({req_fire_s, free_s})
      2'b10:   inflight_nxt_s = inflight_r + {{TAG_W{1'b0}}, 1'b1};
      2'b01:   inflight_nxt_s = inflight_r - {{TAG_W{1'b0}}, 1'b1};
      default: inflight_nxt_s = inflight_r;
    endcase
  end

  // Tag table: clear on forwarded response, then set on accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        type_r[i] <= 6'd0;
      end
`ifdef RVH_RUBY_RESP_CHECK_EN
      is_ld_r <= {DEPTH{1'b0}};
`endif
    end else begin
      if (fwd_s) begin
        valid_r[rsp_tag_s] <= 1'b0;
      end
      if (req_fire_s) begin
        valid_r[ruby_req_tag_i] <= 1'b1;
        type_r[ruby_req_tag_i]  <= ruby_req_type_i;
`ifdef RVH_RUBY_RESP_CHECK_EN
        is_ld_r[ruby_req_tag_i] <= type_is_ld(ruby_req_type_i);
`endif
      end
    end
  end

  // Output register: load on forward, drop valid once ruby takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_r <= 1'b0;
      resp_type_r  <= 6'd0;
      resp_tag_r   <= {TAG_W{1'b0}};
      resp_data_r  <= {DATA_W{1'b0}};
    end else if (fwd_s) begin
      resp_valid_r <= 1'b1;
      resp_type_r  <= type_r[rsp_tag_s];
      resp_tag_r   <= rsp_tag_s;
      resp_data_r  <= rsp_data_s;
    end else if (ruby_resp_ready_i) begin
      resp_valid_r <= 1'b0;
    end
  end

  // Inflight counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_r <= {(TAG_W+1){1'b0}};
    end else begin
      inflight_r <= inflight_nxt_s;
    end
  end

`ifdef RVH_RUBY_RESP_CHECK_EN
  // Sticky error for responses to idle tags or with the wrong load/store kind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_err_r <= 1'b0;
    end else if (rsp_fire_s && bad_s) begin
      resp_err_r <= 1'b1;
    end
  end

  assign resp_err_o = resp_err_r;
`endif

  assign ruby_req_ready_o  = !valid_r[ruby_req_tag_i];
  assign ld_resp_ready_o   = out_free_s;
  assign st_resp_ready_o   = out_free_s && !ld_resp_valid_i;
  assign ruby_resp_valid_o = resp_valid_r;
  assign ruby_resp_type_o  = resp_type_r;
  assign ruby_resp_tag_o   = resp_tag_r;
  assign ruby_resp_data_o  = resp_data_r;
  assign inflight_cnt_o    = inflight_r;

endmodule

// File: doc/rvh2rrv_ruby_resp_packer.md
RVH2RRV_RUBY_RESP_PACKER -- requirements
Module: rvh2rrv_ruby_resp_packer

Interface
REQ-001 SHALL have parameter TAG_W, default 3, ruby tag width; tracking depth is 2^TAG_W entries.
REQ-002 SHALL have parameter DATA_W, default 64, load response data width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port ruby_req_valid_i, input, 1: ruby request offered.
REQ-006 SHALL have port ruby_req_ready_o, output, 1: request accepted this cycle.
REQ-007 SHALL have port ruby_req_type_i, input, 6: rrv64 ruby request type, codes 0..38.
REQ-008 SHALL have port ruby_req_tag_i, input, TAG_W: request tag.
REQ-009 SHALL have ports ld_resp_valid_i / ld_resp_ready_o / ld_resp_tag_i / ld_resp_data_i, in/out/in/in, 1/1/TAG_W/DATA_W: L1D load response.
REQ-010 SHALL have ports st_resp_valid_i / st_resp_ready_o / st_resp_tag_i, in/out/in, 1/1/TAG_W: L1D store response.
REQ-011 SHALL have ports ruby_resp_valid_o / ruby_resp_ready_i / ruby_resp_type_o / ruby_resp_tag_o / ruby_resp_data_o, out/in/out/out/out, 1/1/6/TAG_W/DATA_W: response to ruby.
REQ-012 SHALL have port inflight_cnt_o, output, TAG_W+1: number of outstanding tags.

Function
REQ-013 SHALL keep per tag a valid bit, the stored 6-bit ruby type and an is_ld bit (1 for types 1..7, 34, 36; else 0).
REQ-014 SHALL drive ruby_req_ready_o = !valid[ruby_req_tag_i], combinationally from registered state.
REQ-015 SHALL on request handshake set valid[tag] and store type and is_ld at next edge.
REQ-016 SHALL hold a single output register; out_free = !ruby_resp_valid_o | ruby_resp_ready_i.
REQ-017 SHALL drive ld_resp_ready_o = out_free; st_resp_ready_o = out_free & !ld_resp_valid_i (load priority).
REQ-018 SHALL on accepted response load the output register next edge: type = stored type[tag], tag echoed, data = ld data for loads, all-zero for stores; latency exactly 1 cycle.
REQ-019 SHALL clear valid[tag] on the same edge a response for it is accepted.
REQ-020 SHALL hold output stable while ruby_resp_valid_o & !ruby_resp_ready_i; back-to-back responses at full rate when ready_i stays high.
REQ-021 SHALL on same-cycle free and request of the same tag: free wins, request stalls (ready low that cycle), accepted next cycle.
REQ-022 SHALL on same-cycle request of tag A and response of tag B (A != B) perform both.
REQ-023 SHALL keep inflight_cnt_o = popcount of valid bits; +1, -1, or unchanged on simultaneous alloc and free; never wraps (max 2^TAG_W).

Reset
REQ-024 SHALL on rst clear all valid bits, ruby_resp_valid_o=0, ruby_resp_type_o=0, ruby_resp_tag_o=0, ruby_resp_data_o=0, inflight_cnt_o=0, immediately and asynchronously.
REQ-025 SHALL discard in-flight responses and tags on reset mid-operation; no response emitted after release until a new request is accepted.

Configuration
REQ-026 SHALL, with RVH_RUBY_RESP_CHECK_EN defined, add output resp_err_o (1 bit, reset 0, sticky until rst) set when an accepted response hits a tag with valid=0 or mismatched is_ld (load resp on store entry or vice versa); such responses are consumed and dropped (no ruby response, no state change).
REQ-027 SHALL, without RVH_RUBY_RESP_CHECK_EN, omit resp_err_o and all checking; every accepted response is forwarded with the stored type regardless of valid/is_ld.

Verification
REQ-028 SHALL cover: request type 2 tag 3; ld resp tag 3 data 0xDEAD_BEEF -> next cycle ruby_resp type 2 tag 3 data 0xDEAD_BEEF, inflight 1->0.
REQ-029 SHALL cover: request type 9 tag 1, st resp tag 1 -> ruby_resp type 9 tag 1 data 0, one cycle later.
REQ-030 SHALL cover: ld resp tag 0 and st resp tag 5 same cycle -> ld_ready=1, st_ready=0; load output first, store next cycle.
REQ-031 SHALL cover: ruby_resp_ready_i low 3 cycles with response pending -> output stable, both L1D readies low, no loss.
REQ-032 SHALL cover: fill all 8 tags -> inflight 8, repeated tag request ready=0; free tag 4 with same-cycle request tag 4 -> request accepted following cycle.
REQ-033 SHALL cover (RVH_RUBY_RESP_CHECK_EN): ld resp on idle tag 6 -> resp_err_o=1 next cycle, no ruby response; assert rst mid-burst -> all outputs 0 at once.
